// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder slice.
// FSM state encoding, default geometry and the latency counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_LATENCY = 4;
  localparam int DEFAULT_DEPTH   = 256;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x 32 backing store: synchronous write, registered read.
// Contents and the read register have no reset so the array maps onto block RAM.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request, stalls the CPU, acks after LATENCY cycles.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = DEFAULT_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [AW-1:0]     idx_q;
  logic [31:0]       wdata_q;
  logic              mis_q;
  logic              mis_now;
  logic              rdata_zero;
  logic              last;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       array_rdata;
  logic              unused_addr;

  assign unused_addr = ^addr_i;

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_now = (addr_i[1:0] != 2'b00);
`else
  assign mis_now = 1'b0;
`endif

  assign stall_o = ((state == IDLE) && req_i) || (state == BUSY);
  assign last    = (state == BUSY) && (cnt == '0);
  assign mem_we  = last && we_q && !mis_q;
  assign mem_re  = last && !we_q && !mis_q;

  // The array's read register is the data holder; rdata_zero masks it after reset or a faulted read.
  assign rdata_o = rdata_zero ? 32'd0 : array_rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      ack_o      <= 1'b0;
      err_o      <= 1'b0;
      rdata_zero <= 1'b1;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      mis_q      <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            idx_q   <= addr_i[AW+1:2];
            wdata_q <= wdata_i;
            mis_q   <= mis_now;
            cnt     <= CNT_LOAD;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= DONE;
            ack_o <= 1'b1;
            err_o <= mis_q;
            if (!we_q) begin
              rdata_zero <= mis_q;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk_i),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (array_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected acks, a negedge monitor checks them.
// A second LATENCY=2 instance covers back-to-back requests with req held high.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        stall, ack, err;

  logic        req2 = 1'b0, we2 = 1'b0;
  logic [31:0] addr2 = '0, wdata2 = '0;
  logic [31:0] rdata2;
  logic        stall2, ack2, err2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          ack_cyc;
    logic [31:0] rdata;
    logic        err;
    bit          chk_rdata;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ref_mem [256];
  logic [31:0] last_rd = 32'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.LATENCY(LAT), .DEPTH(256)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .stall_o(stall), .ack_o(ack), .err_o(err)
  );

  dmem_responder #(.LATENCY(2), .DEPTH(256)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req2), .we_i(we2), .addr_i(addr2), .wdata_i(wdata2),
    .rdata_o(rdata2), .stall_o(stall2), .ack_o(ack2), .err_o(err2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: every ack from the main instance must match the oldest expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack at cycle %0d required none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
        chk("err", {31'd0, err}, {31'd0, mon_e.err});
        if (mon_e.chk_rdata) chk("rdata", rdata, mon_e.rdata);
        $display("ack at cycle %0d rdata=%h err=%b", cyc, rdata, err);
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input bit scramble);
    exp_t e;
    bit   mis;
    bit   got;
    int   t;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    #1;
    chk("stall_accept", {31'd0, stall}, 32'd1);
    t   = cyc;
    mis = ALIGN && (a[1:0] != 2'b00);
    e.ack_cyc = t + LAT;
    e.err     = mis;
    if (!w) begin
      e.rdata     = mis ? 32'd0 : ref_mem[a[9:2]];
      last_rd     = e.rdata;
      e.chk_rdata = 1'b1;
    end else begin
      if (!mis) ref_mem[a[9:2]] = d;
      e.rdata     = last_rd;
      e.chk_rdata = !mis;
    end
    sb.push_back(e);
    $display("issue %s addr=%h wdata=%h at cycle %0d", w ? "WR" : "RD", a, d, t);
    @(posedge clk);
    #1;
    req = 1'b0;
    if (scramble) begin
      addr = a ^ 32'h60; we = ~w; wdata = ~d;
    end
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      chk("stall_busy", {31'd0, stall}, 32'd1);
    end
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ack === 1'b1) got = 1'b1;
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    chk("stall_done", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    int t;
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Write then read, then aliased read through the wrapped index
    issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 1'b0);
    issue(1'b0, 32'h410, 32'h0, 1'b0);

    // Reset during BUSY must abort a pending write
    issue(1'b1, 32'h20, 32'h11111111, 1'b0);
    issue(1'b0, 32'h20, 32'h0, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678;
    t0 = cyc;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    $display("reset asserted in cycle %0d after accept in cycle %0d", cyc, t0);
    #1;
    chk("abort_ack", {31'd0, ack}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'd0;
    issue(1'b0, 32'h20, 32'h0, 1'b0);

    // Inputs scrambled during BUSY must not affect the latched read
    issue(1'b1, 32'h30, 32'h55AA55AA, 1'b0);
    issue(1'b0, 32'h30, 32'h0, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 1'b0);

    // Index boundaries and upper address bits ignored
    issue(1'b1, 32'h3FC, 32'hFFFFFFFF, 1'b0);
    issue(1'b1, 32'hF000_0000, 32'h13572468, 1'b0);
    issue(1'b0, 32'h0000_07FC, 32'h0, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 1'b0);
    issue(1'b1, 32'h44, 32'h00000000, 1'b1);
    issue(1'b0, 32'h44, 32'h0, 1'b0);

    // Misaligned accesses
    issue(1'b0, 32'h13, 32'h0, 1'b0);
    issue(1'b1, 32'h13, 32'hFFFFFFFF, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 1'b0);

    // LATENCY=2 instance: req held high across two requests
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h8; wdata2 = 32'hA5A5A5A5;
    #1 chk("l2_stall_t0", {31'd0, stall2}, 32'd1);
    @(negedge clk);
    chk("l2_ack_t1", {31'd0, ack2}, 32'd0);
    chk("l2_stall_t1", {31'd0, stall2}, 32'd1);
    @(negedge clk);
    chk("l2_ack_t2", {31'd0, ack2}, 32'd1);
    chk("l2_stall_t2", {31'd0, stall2}, 32'd0);
    chk("l2_err_t2", {31'd0, err2}, 32'd0);
    we2 = 1'b0; wdata2 = 32'h0;
    @(negedge clk);
    chk("l2_ack_t3", {31'd0, ack2}, 32'd0);
    chk("l2_stall_t3", {31'd0, stall2}, 32'd1);
    @(negedge clk);
    chk("l2_ack_t4", {31'd0, ack2}, 32'd0);
    chk("l2_stall_t4", {31'd0, stall2}, 32'd1);
    @(negedge clk);
    chk("l2_ack_t5", {31'd0, ack2}, 32'd1);
    chk("l2_rdata_t5", rdata2, 32'hA5A5A5A5);
    $display("latency2 read ack at cycle %0d rdata=%h", cyc, rdata2);
    req2 = 1'b0;
    @(negedge clk);
    chk("l2_ack_t6", {31'd0, ack2}, 32'd0);
    chk("l2_stall_t6", {31'd0, stall2}, 32'd0);

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
